sc_cfg_commit_scheduler: RTL and testbench

//  Shadow/commit controller for the scanconverter output timing, crop and scanline config words. CPU-side writes land in a shadow bank.
//  A commit request is deferred to the next output VSYNC leading edge, so all eight active words change atomically between frames.

---
 rtl/sc_cfg_commit_scheduler.sv | 161 ++++++++++++++++
 tb/tb_sc_cfg_commit_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_cfg_commit_scheduler.sv
// Shadow/commit controller for the scanconverter config words: CPU writes land in a shadow bank,
// commits apply atomically at the next output VSYNC leading edge. Optional macro: SC_CFG_READBACK_EN.
module sc_cfg_commit_scheduler #(
  parameter int unsigned TIMEOUT_W      = 22,
  parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
  input  logic        PCLK_OUT_i,
  input  logic        reset_n,
  input  logic        cfg_wr_valid_i,
  input  logic [2:0]  cfg_wr_addr_i,
  input  logic [31:0] cfg_wr_data_i,
  output logic        cfg_wr_ready_o,
  input  logic        commit_req_i,
  input  logic        VSYNC_i,
  input  logic        resync_strobe_i,
  output logic        commit_busy_o,
  output logic        commit_done_o,
  output logic        commit_timeout_o,
  output logic [15:0] frame_cnt_o,
  output logic [31:0] hv_out_config_o,
  output logic [31:0] hv_out_config2_o,
  output logic [31:0] hv_out_config3_o,
  output logic [31:0] xy_out_config_o,
  output logic [31:0] xy_out_config2_o,
  output logic [31:0] misc_config_o,
  output logic [31:0] sl_config_o,
`ifdef SC_CFG_READBACK_EN
  output logic [31:0] sl_config2_o,
  input  logic [2:0]  cfg_rd_addr_i,
  output logic [31:0] cfg_rd_data_o
`else
  output logic [31:0] sl_config2_o
`endif
);

  typedef enum logic [1:0] {StIdle, StArmed, StApply} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            shadow_q [8];
  logic [31:0]            shadow_d [8];
  logic [31:0]            active_q [8];
  logic [31:0]            active_d [8];
  logic [7:0]             dirty_q, dirty_d;
  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   tmo_q, tmo_d;
  logic                   vs_prev_q;
  logic                   vs_start_q;
  logic [15:0]            frame_q;
  logic                   vs_start;
  logic                   wr_en;
  logic                   tmo_hit;

  assign vs_start = vs_prev_q & ~VSYNC_i;
  assign wr_en    = cfg_wr_valid_i && (state_q == StIdle);
  assign tmo_hit  = (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    tmo_d    = tmo_q;

    if (wr_en) begin
      shadow_d[cfg_wr_addr_i] = cfg_wr_data_i;
      dirty_d[cfg_wr_addr_i]  = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (commit_req_i) begin
          tmo_d = 1'b0;
          // A clean bank completes immediately; only previously dirty words arm a commit.
          if (dirty_q == 8'h00) begin
            done_d = 1'b1;
          end else begin
            state_d = StArmed;
          end
        end
      end
      StArmed: begin
        cnt_d = cnt_q + 1'b1;
        if (vs_start_q || resync_strobe_i || tmo_hit) begin
          state_d = StApply;
          if (tmo_hit && !vs_start_q && !resync_strobe_i) begin
            tmo_d = 1'b1;
          end
        end
      end
      StApply: begin
        active_d = shadow_q;
        dirty_d  = 8'h00;
        cnt_d    = '0;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK_OUT_i) begin
    // Sampled even in reset so a VSYNC already low at release is not taken as an edge.
    vs_prev_q <= VSYNC_i;
    if (!reset_n) begin
      state_q    <= StIdle;
      shadow_q   <= '{default: '0};
      active_q   <= '{default: '0};
      dirty_q    <= 8'h00;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      vs_start_q <= 1'b0;
      frame_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      dirty_q    <= dirty_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
      vs_start_q <= vs_start;
      if (vs_start) begin
        frame_q <= frame_q + 16'd1;
      end
    end
  end

`ifdef SC_CFG_READBACK_EN
  logic [31:0] rd_data_q;

  always_ff @(posedge PCLK_OUT_i) begin
    if (!reset_n) begin
      rd_data_q <= 32'h0;
    end else begin
      rd_data_q <= dirty_q[cfg_rd_addr_i] ? shadow_q[cfg_rd_addr_i] : active_q[cfg_rd_addr_i];
    end
  end

  assign cfg_rd_data_o = rd_data_q;
`endif

  assign cfg_wr_ready_o   = (state_q == StIdle);
  assign commit_busy_o    = (state_q == StArmed);
  assign commit_done_o    = done_q;
  assign commit_timeout_o = tmo_q;
  assign frame_cnt_o      = frame_q;

  assign hv_out_config_o  = active_q[0];
  assign hv_out_config2_o = active_q[1];
  assign hv_out_config3_o = active_q[2];
  assign xy_out_config_o  = active_q[3];
  assign xy_out_config2_o = active_q[4];
  assign misc_config_o    = active_q[5];
  assign sl_config_o      = active_q[6];
  assign sl_config2_o     = active_q[7];

endmodule

// File: tb/tb_sc_cfg_commit_scheduler.sv
// Directed bench for sc_cfg_commit_scheduler: vector table of write/commit/trigger records plus
// hand sequences for reset, timeout, held writes and frame counting.
module tb_sc_cfg_commit_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        commit_req;
  logic        vsync;
  logic        resync;
  logic        busy;
  logic        done;
  logic        tmo;
  logic [15:0] frame_cnt;
  logic [31:0] act [8];
`ifdef SC_CFG_READBACK_EN
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sc_cfg_commit_scheduler #(
    .TIMEOUT_W      (22),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .PCLK_OUT_i       (clk),
    .reset_n          (reset_n),
    .cfg_wr_valid_i   (wr_valid),
    .cfg_wr_addr_i    (wr_addr),
    .cfg_wr_data_i    (wr_data),
    .cfg_wr_ready_o   (wr_ready),
    .commit_req_i     (commit_req),
    .VSYNC_i          (vsync),
    .resync_strobe_i  (resync),
    .commit_busy_o    (busy),
    .commit_done_o    (done),
    .commit_timeout_o (tmo),
    .frame_cnt_o      (frame_cnt),
    .hv_out_config_o  (act[0]),
    .hv_out_config2_o (act[1]),
    .hv_out_config3_o (act[2]),
    .xy_out_config_o  (act[3]),
    .xy_out_config2_o (act[4]),
    .misc_config_o    (act[5]),
    .sl_config_o      (act[6]),
`ifdef SC_CFG_READBACK_EN
    .sl_config2_o     (act[7]),
    .cfg_rd_addr_i    (rd_addr),
    .cfg_rd_data_o    (rd_data)
`else
    .sl_config2_o     (act[7])
`endif
  );

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    bit          use_resync;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] shadow_m [8];
  logic [31:0] active_m [8];
  int          fexp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    shadow_m[a] = d;
  endtask

  task automatic commit();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  // Waits a bounded number of cycles for the done pulse; on success the model applies.
  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      tick();
      if (done) got = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    active_m = shadow_m;
  endtask

  task automatic chk_all(input string name);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_word%0d", name, i), act[i], active_m[i]);
  endtask

  initial begin
    vecs[0] = '{3'd0, 32'hA5A5_0001, 1'b0};
    vecs[1] = '{3'd1, 32'h0000_FFFF, 1'b1};
    vecs[2] = '{3'd2, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{3'd3, 32'h1357_9BDF, 1'b1};
    vecs[4] = '{3'd4, 32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{3'd5, 32'h8000_0000, 1'b1};
    vecs[6] = '{3'd6, 32'h0246_8ACE, 1'b0};
    vecs[7] = '{3'd7, 32'h0000_0001, 1'b1};
    shadow_m = '{default: '0};
    active_m = '{default: '0};
    fexp = 0;

    reset_n = 1'b0; wr_valid = 1'b0; wr_addr = 3'd0; wr_data = 32'h0;
    commit_req = 1'b0; vsync = 1'b0; resync = 1'b0;
`ifdef SC_CFG_READBACK_EN
    rd_addr = 3'd0;
`endif

    // Reset with VSYNC held low.
    repeat (3) tick();
    chk_all("rst");
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    reset_n = 1'b1;
    repeat (5) tick();
    chk("rel_low_no_edge", 32'(frame_cnt), 32'd0);
    vsync = 1'b1; tick();
    vsync = 1'b0; tick();
    fexp++;
    chk("first_edge", 32'(frame_cnt), 32'(fexp));
    vsync = 1'b1; tick();

    // VSYNC-triggered commit and its two-cycle latency.
    wr(3'd0, 32'h1234_5898);
    commit();
    chk("armed_busy", 32'(busy), 32'd1);
    chk("armed_ready", 32'(wr_ready), 32'd0);
    repeat (40) tick();
    chk("armed_still_busy", 32'(busy), 32'd1);
    vsync = 1'b0; tick();
    fexp++;
    chk("vs_frame", 32'(frame_cnt), 32'(fexp));
    chk("vs_m0_hv", act[0], 32'h0);
    vsync = 1'b1; tick();
    chk("vs_m1_hv", act[0], 32'h0);
    chk("vs_m1_done", 32'(done), 32'd0);
    tick();
    chk("vs_m2_hv", act[0], 32'h1234_5898);
    chk("vs_m2_done", 32'(done), 32'd1);
    active_m = shadow_m;
    tick();
    chk("vs_done_once", 32'(done), 32'd0);
    chk("vs_tmo", 32'(tmo), 32'd0);

    // Commit with a clean bank.
    commit();
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_busy", 32'(busy), 32'd0);
    tick();
    chk("empty_done_off", 32'(done), 32'd0);
    chk_all("empty");

    // Table of single-word commits via VSYNC or resync.
    for (int v = 0; v < 8; v++) begin
      wr(vecs[v].addr, vecs[v].data);
      commit();
      tick();
      if (vecs[v].use_resync) begin
        resync = 1'b1;
      end else begin
        vsync = 1'b0;
        fexp++;
      end
      tick();
      resync = 1'b0;
      vsync  = 1'b1;
      wait_done($sformatf("vec%0d", v));
      chk_all($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_tmo", v), 32'(tmo), 32'd0);
    end
    chk("vec_frame", 32'(frame_cnt), 32'(fexp));

    // Timeout-forced apply after 64 ARMED cycles.
    begin
      int busy_drop = 0;
      wr(3'd1, 32'hC0DE_0064);
      commit();
      for (int k = 1; k < 64; k++) begin
        tick();
        if (!busy) busy_drop++;
      end
      chk("tmo_busy_63", 32'(busy_drop), 32'd0);
      tick();
      chk("tmo_apply_busy", 32'(busy), 32'd0);
      chk("tmo_flag", 32'(tmo), 32'd1);
      chk("tmo_not_yet", act[1], active_m[1]);
      tick();
      chk("tmo_done", 32'(done), 32'd1);
      active_m = shadow_m;
      chk("tmo_word", act[1], 32'hC0DE_0064);
      repeat (3) tick();
      chk("tmo_sticky", 32'(tmo), 32'd1);
      commit();
      chk("tmo_cleared", 32'(tmo), 32'd0);
      tick();
    end

    // Write held while ARMED, then resync apply.
    wr(3'd2, 32'h1111_2222);
    commit();
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 32'h3333_4444;
    repeat (3) tick();
    chk("held_ready", 32'(wr_ready), 32'd0);
    resync = 1'b1; tick();
    resync = 1'b0;
    chk("held_apply_nodone", 32'(done), 32'd0);
    tick();
    chk("held_done", 32'(done), 32'd1);
    chk("held_ready_idle", 32'(wr_ready), 32'd1);
    chk("held_word_old", act[2], 32'h1111_2222);
    active_m = shadow_m;
    tick();
    wr_valid = 1'b0;
    shadow_m[2] = 32'h3333_4444;
`ifdef SC_CFG_READBACK_EN
    rd_addr = 3'd2; tick();
    chk("rb_dirty_shadow", rd_data, 32'h3333_4444);
    rd_addr = 3'd0; tick();
    chk("rb_clean_active", rd_data, active_m[0]);
`endif
    chk("held_active_kept", act[2], 32'h1111_2222);
    commit();
    tick();
    vsync = 1'b0; tick();
    fexp++;
    vsync = 1'b1;
    wait_done("held2");
    chk("held2_word", act[2], 32'h3333_4444);
`ifdef SC_CFG_READBACK_EN
    rd_addr = 3'd2; tick();
    chk("rb_after_apply", rd_data, 32'h3333_4444);
`endif

    // Burst of VSYNC edges.
    repeat (300) begin
      vsync = 1'b0; tick();
      vsync = 1'b1; tick();
    end
    fexp += 300;
    chk("burst_frame", 32'(frame_cnt), 32'(fexp % 65536));

    // Reset while ARMED abandons the commit.
    wr(3'd5, 32'h5555_AAAA);
    commit();
    repeat (3) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b0; tick();
    reset_n = 1'b1;
    active_m = '{default: '0};
    chk("armrst_busy", 32'(busy), 32'd0);
    chk("armrst_ready", 32'(wr_ready), 32'd1);
    chk("armrst_frame", 32'(frame_cnt), 32'd0);
    tick();
    chk("armrst_no_done", 32'(done), 32'd0);
    chk_all("armrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
